// File: rtl/video_memory_sequencer_if.sv
// Host, command and memory-port signal bundle for the video memory sequencer.
// The master side is the host/display environment; the slave side is the sequencer.
interface video_memory_sequencer_if #(
    parameter int ATTR_W = 32,
    parameter int ADDR_W = 12
);
    logic              wr_valid;
    logic              wr_ready;
    logic [6:0]        wr_x;
    logic [4:0]        wr_y;
    logic [ATTR_W-1:0] wr_value;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [ATTR_W-1:0] cmd_value;

    logic              mem_slot;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [ATTR_W-1:0] mem_wdata;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_raddr;
    logic [ATTR_W-1:0] mem_rdata;

    logic              busy;
    logic              drop;

    modport master (
        output wr_valid, wr_x, wr_y, wr_value,
        output cmd_valid, cmd_op, cmd_value,
        output mem_slot, mem_rdata,
        input  wr_ready, cmd_ready,
        input  mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr,
        input  busy, drop
    );

    modport slave (
        input  wr_valid, wr_x, wr_y, wr_value,
        input  cmd_valid, cmd_op, cmd_value,
        input  mem_slot, mem_rdata,
        output wr_ready, cmd_ready,
        output mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr,
        output busy, drop
    );
endinterface

// File: rtl/video_memory_sequencer.sv
// Write-side controller for character/attribute video memory: buffered host writes,
// clear-screen and scroll-up, with every memory access confined to display-free slots.
module video_memory_sequencer #(
    parameter int COLS       = 80,
    parameter int ROWS       = 30,
    parameter int ATTR_W     = 32,
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    video_memory_sequencer_if.slave  bus
);
    localparam int                PTR_W         = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] COLS_A        = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_A        = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] SCROLL_LAST_A = ADDR_W'((ROWS - 1) * COLS - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SC_RD,
        SC_CAP,
        SC_WR,
        SC_FILL
    } state_t;

    state_t state, state_n;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [ATTR_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W:0]    wp, rp;
    logic              empty, full, in_range, accept, push, pop;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] a;
    logic [ATTR_W-1:0] fill_q, cap_q;
    logic              drop_q, start, inc_a;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty    = (wp == rp);
    assign full     = (wp[PTR_W] != rp[PTR_W]) && (wp[PTR_W-1:0] == rp[PTR_W-1:0]);
    assign in_range = (int'(bus.wr_x) < COLS) && (int'(bus.wr_y) < ROWS);
    assign accept   = bus.wr_valid && !full;
    assign push     = accept && in_range;
    assign wr_addr  = ADDR_W'(bus.wr_y) * COLS_A + ADDR_W'(bus.wr_x);

    assign bus.wr_ready  = !full;
    assign bus.cmd_ready = (state == IDLE) && empty && !bus.wr_valid;
    assign bus.busy      = (state != IDLE) || !empty;
    assign bus.drop      = drop_q;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wp[PTR_W-1:0]] <= wr_addr;
            fifo_data[wp[PTR_W-1:0]] <= bus.wr_value;
        end
    end

    always_comb begin
        state_n       = state;
        pop           = 1'b0;
        start         = 1'b0;
        inc_a         = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_re    = 1'b0;
        bus.mem_waddr = '0;
        bus.mem_raddr = '0;
        bus.mem_wdata = '0;
        unique case (state)
            IDLE: begin
                if (!empty && bus.mem_slot) begin
                    pop           = 1'b1;
                    bus.mem_we    = 1'b1;
                    bus.mem_waddr = fifo_addr[rp[PTR_W-1:0]];
                    bus.mem_wdata = fifo_data[rp[PTR_W-1:0]];
                end else if (bus.cmd_valid && bus.cmd_ready) begin
                    start   = 1'b1;
                    state_n = bus.cmd_op ? SC_RD : CLEAR;
                end
            end
            CLEAR, SC_FILL: begin
                if (bus.mem_slot) begin
                    bus.mem_we    = 1'b1;
                    bus.mem_waddr = a;
                    bus.mem_wdata = fill_q;
                    inc_a         = 1'b1;
                    if (a == LAST_A) state_n = IDLE;
                end
            end
            SC_RD: begin
                if (bus.mem_slot) begin
                    bus.mem_re    = 1'b1;
                    bus.mem_raddr = a + COLS_A;
                    state_n       = SC_CAP;
                end
            end
            SC_CAP: state_n = SC_WR;
            SC_WR: begin
                if (bus.mem_slot) begin
                    bus.mem_we    = 1'b1;
                    bus.mem_waddr = a;
                    bus.mem_wdata = cap_q;
                    inc_a         = 1'b1;
                    state_n       = (a == SCROLL_LAST_A) ? SC_FILL : SC_RD;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            wp     <= '0;
            rp     <= '0;
            a      <= '0;
            fill_q <= '0;
            cap_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            state  <= state_n;
            drop_q <= accept && !in_range;
            if (push) wp <= wp + (PTR_W + 1)'(1);
            if (pop)  rp <= rp + (PTR_W + 1)'(1);
            if (start) begin
                a      <= '0;
                fill_q <= bus.cmd_value;
            end else if (inc_a) begin
                a <= a + ADDR_W'(1);
            end
            // Read data arrives the cycle after mem_re, which is always SC_CAP.
            if (state == SC_CAP) cap_q <= bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_video_memory_sequencer.sv
// Scoreboard bench for video_memory_sequencer: expected writes are queued at stimulus
// time and matched against every mem_we observed on the memory port.
module tb_video_memory_sequencer;
    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int ATTR_W = 32;
    localparam int ADDR_W = 12;
    localparam int CELLS  = COLS * ROWS;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [ATTR_W-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    video_memory_sequencer_if #(.ATTR_W(ATTR_W), .ADDR_W(ADDR_W)) bus ();

    video_memory_sequencer #(
        .COLS(COLS), .ROWS(ROWS), .ATTR_W(ATTR_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    wr_t               exp_q[$];
    int                checks = 0;
    int                errors = 0;
    logic [ATTR_W-1:0] vmem [4096];
    logic [ATTR_W-1:0] rd_next = '0;
    int                slot_mode = 0;
    bit                sb_on = 1'b1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input int addr, input logic [ATTR_W-1:0] data);
        wr_t e;
        e.addr = ADDR_W'(addr);
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Slot generator: 0 = never free, 1 = always free, 2 = alternate, 3 = random.
    initial forever begin
        @(posedge clk);
        #1;
        case (slot_mode)
            0:       bus.mem_slot = 1'b0;
            1:       bus.mem_slot = 1'b1;
            2:       bus.mem_slot = !bus.mem_slot;
            default: bus.mem_slot = 1'($urandom_range(0, 1));
        endcase
    end

    initial forever begin
        @(posedge clk);
        #1;
        bus.mem_rdata = rd_next;
    end

    // Memory model and scoreboard monitor.
    initial forever begin
        wr_t e;
        @(negedge clk);
        if (bus.mem_we || bus.mem_re) begin
            chk("slot_rule", 64'(bus.mem_slot), 64'(1));
            chk("we_re_excl", 64'(bus.mem_we & bus.mem_re), 64'(0));
        end
        if (bus.mem_re) rd_next = vmem[bus.mem_raddr];
        if (bus.mem_we) begin
            vmem[bus.mem_waddr] = bus.mem_wdata;
            if (sb_on) begin
                if (exp_q.size() == 0) begin
                    chk("we_extra", 64'(exp_q.size()), 64'(1));
                end else begin
                    e = exp_q.pop_front();
                    chk("waddr", 64'(bus.mem_waddr), 64'(e.addr));
                    chk("wdata", 64'(bus.mem_wdata), 64'(e.data));
                end
            end
        end
    end

    task automatic host_write(input int x, input int y, input logic [ATTR_W-1:0] v);
        bit done = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_x     = 7'(x);
        bus.wr_y     = 5'(y);
        bus.wr_value = v;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (bus.wr_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.wr_valid = 1'b0;
        chk("wr_accept", 64'(done), 64'(1));
        if (done && x < COLS && y < ROWS) push_exp(y * COLS + x, v);
    endtask

    task automatic issue_cmd(input logic op, input logic [ATTR_W-1:0] v);
        bit done = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_value = v;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
        chk("cmd_accept", 64'(done), 64'(1));
    endtask

    task automatic wait_idle(input int budget, output int cyc);
        cyc = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            cyc++;
        end
        chk("idle", 64'(bus.busy), 64'(0));
        chk("sb_drained", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string p);
        chk({p, "_we"},        64'(bus.mem_we),    64'(0));
        chk({p, "_re"},        64'(bus.mem_re),    64'(0));
        chk({p, "_waddr"},     64'(bus.mem_waddr), 64'(0));
        chk({p, "_raddr"},     64'(bus.mem_raddr), 64'(0));
        chk({p, "_wdata"},     64'(bus.mem_wdata), 64'(0));
        chk({p, "_busy"},      64'(bus.busy),      64'(0));
        chk({p, "_drop"},      64'(bus.drop),      64'(0));
        chk({p, "_wr_ready"},  64'(bus.wr_ready),  64'(1));
        chk({p, "_cmd_ready"}, 64'(bus.cmd_ready), 64'(1));
    endtask

    task automatic preload();
        for (int i = 0; i < 4096; i++) vmem[i] = ATTR_W'(i);
    endtask

    task automatic push_scroll(input logic [ATTR_W-1:0] fill);
        for (int i = 0; i < (ROWS - 1) * COLS; i++) push_exp(i, ATTR_W'(i + COLS));
        for (int i = (ROWS - 1) * COLS; i < CELLS; i++) push_exp(i, fill);
    endtask

    initial begin
        int cyc;
        bus.wr_valid  = 1'b0;
        bus.wr_x      = '0;
        bus.wr_y      = '0;
        bus.wr_value  = '0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
        bus.cmd_value = '0;
        bus.mem_slot  = 1'b0;
        bus.mem_rdata = '0;
        for (int i = 0; i < 4096; i++) vmem[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single write at full slot rate: mem_we the cycle after enqueue.
        slot_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        host_write(3, 2, 32'hA5A5_0041);
        @(negedge clk);
        chk("sw_we", 64'(bus.mem_we), 64'(1));
        chk("sw_waddr", 64'(bus.mem_waddr), 64'(163));
        chk("sw_busy", 64'(bus.busy), 64'(1));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("sw_busy_fall", 64'(bus.busy), 64'(0));
        chk("sw_we_once", 64'(bus.mem_we), 64'(0));
        @(posedge clk);
        #1;

        // Backpressure with no free slots; a pending write also holds off commands.
        slot_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        bus.wr_x     = 7'd1;
        bus.wr_y     = 5'd1;
        bus.wr_valid = 1'b1;
        #1;
        chk("cmd_ready_wr_pending", 64'(bus.cmd_ready), 64'(0));
        host_write(1, 1, 32'h0000_1001);
        host_write(79, 29, 32'h0000_1002);
        host_write(0, 0, 32'h0000_1003);
        host_write(40, 15, 32'h0000_1004);
        @(negedge clk);
        chk("bp_full", 64'(bus.wr_ready), 64'(0));
        chk("bp_busy", 64'(bus.busy), 64'(1));
        chk("bp_cmd_ready", 64'(bus.cmd_ready), 64'(0));
        @(posedge clk);
        #1;
        fork
            host_write(10, 3, 32'h0000_1005);
            begin
                repeat (4) @(posedge clk);
                slot_mode = 1;
            end
        join
        wait_idle(100, cyc);

        // Out-of-range writes are swallowed with a one-cycle drop pulse.
        host_write(80, 0, 32'hDEAD_0001);
        @(negedge clk);
        chk("drop_x", 64'(bus.drop), 64'(1));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("drop_x_clr", 64'(bus.drop), 64'(0));
        @(posedge clk);
        #1;
        host_write(0, 30, 32'hDEAD_0002);
        @(negedge clk);
        chk("drop_y", 64'(bus.drop), 64'(1));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("drop_y_clr", 64'(bus.drop), 64'(0));
        chk("drop_busy", 64'(bus.busy), 64'(0));
        @(posedge clk);
        #1;

        // Clear with alternating slots.
        slot_mode = 2;
        issue_cmd(1'b0, 32'h0000_0020);
        for (int i = 0; i < CELLS; i++) push_exp(i, 32'h0000_0020);
        wait_idle(10000, cyc);
        chk("clr_sparse_cmd_ready", 64'(bus.cmd_ready), 64'(1));

        // Clear at full rate: one write per cycle.
        slot_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        issue_cmd(1'b0, 32'h0700_0020);
        for (int i = 0; i < CELLS; i++) push_exp(i, 32'h0700_0020);
        wait_idle(5000, cyc);
        chk("clr_cycles", 64'(cyc), 64'(CELLS));

        // Scroll with random slots and a host write buffered behind it.
        preload();
        slot_mode = 3;
        issue_cmd(1'b1, 32'h0000_00FF);
        push_scroll(32'h0000_00FF);
        host_write(5, 5, 32'h1234_5678);
        wait_idle(40000, cyc);

        // Scroll at full rate: three cycles per moved cell plus the fill row.
        preload();
        slot_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        issue_cmd(1'b1, 32'h0000_00FF);
        push_scroll(32'h0000_00FF);
        wait_idle(10000, cyc);
        chk("scr_cycles", 64'(cyc), 64'(3 * (ROWS - 1) * COLS + COLS));

        // Reset in the middle of a scroll.
        sb_on = 1'b0;
        issue_cmd(1'b1, 32'h0000_0000);
        repeat (100) @(posedge clk);
        #1;
        chk("mid_scroll_busy", 64'(bus.busy), 64'(1));
        reset = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk);
        #1;
        sb_on = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        chk("post_rst_busy", 64'(bus.busy), 64'(0));
        @(posedge clk);
        #1;
        host_write(0, 0, 32'h0000_CAFE);
        wait_idle(100, cyc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
